// File: rtl/control_pid_mc.sv
// Multi-channel incremental PID with one shared multiplier: u = sat(u1 + (c1*e + c2*e1 + c3*e2) >>> FRAC).
// Latency 6 cycles strobe->dataf_oo, 1 sample per 7 cycles; no backpressure, strobes while busy are dropped and flagged.
module control_pid_mc #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 16,
    parameter int FRAC = 0,
    parameter int NCH  = 2,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic                 dataf_i,
    input  logic [CHW-1:0]       ch_i,
    input  logic [DW-1:0]        ref_i,
    input  logic [DW-1:0]        y_k_i,
    input  logic signed [CW-1:0] coeff_1,
    input  logic signed [CW-1:0] coeff_2,
    input  logic signed [CW-1:0] coeff_3,
    output logic signed [OW-1:0] servo_o,
    output logic [CHW-1:0]       ch_o,
    output logic                 dataf_oo,
    output logic                 busy_o,
    output logic                 sat_o,
    output logic                 overrun_o
);
    localparam int EW = DW + 1;
    localparam int PW = CW + DW + 1;
    localparam int AW = OW + FRAC + 4;
    localparam int TW = AW + 1;
    localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MAC0, S_MAC1, S_MAC2, S_SAT, S_OUT
    } state_t;

    state_t                r_state;
    logic [CHW-1:0]        r_ch;
    logic [DW-1:0]         r_ref;
    logic [DW-1:0]         r_y;
    logic signed [CW-1:0]  r_c1, r_c2, r_c3;
    logic signed [EW-1:0]  r_e, r_e1, r_e2;
    logic signed [OW-1:0]  r_u1;
    logic signed [AW-1:0]  r_acc;
    logic signed [EW-1:0]  r_hist_e1 [NCH];
    logic signed [EW-1:0]  r_hist_e2 [NCH];
    logic signed [OW-1:0]  r_hist_u1 [NCH];

    logic                  w_ch_ok;
    logic signed [EW-1:0]  w_e;
    logic signed [CW-1:0]  w_mul_c;
    logic signed [EW-1:0]  w_mul_e;
    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_acc_nxt;
    logic signed [AW-1:0]  w_acc_sh;
    logic signed [TW-1:0]  w_t;
    logic                  w_sat_hi, w_sat_lo;
    logic signed [OW-1:0]  w_clamped;

    assign w_ch_ok = (32'(ch_i) < NCH);
    assign w_e     = $signed({1'b0, r_ref}) - $signed({1'b0, r_y});

    // Single multiplier shared across the three MAC states.
    always_comb begin
        w_mul_c = r_c1;
        w_mul_e = r_e;
        case (r_state)
            S_MAC1: begin
                w_mul_c = r_c2;
                w_mul_e = r_e1;
            end
            S_MAC2: begin
                w_mul_c = r_c3;
                w_mul_e = r_e2;
            end
            default: ;
        endcase
    end

    assign w_prod    = PW'(w_mul_c) * PW'(w_mul_e);
    assign w_acc_nxt = r_acc + AW'(w_prod);
    assign w_acc_sh  = r_acc >>> FRAC;
    assign w_t       = TW'(r_u1) + TW'(w_acc_sh);
    assign w_sat_hi  = (w_t > TW'(OMAX));
    assign w_sat_lo  = (w_t < TW'(OMIN));
    assign w_clamped = w_sat_hi ? OMAX : (w_sat_lo ? OMIN : w_t[OW-1:0]);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_ref     <= '0;
            r_y       <= '0;
            r_c1      <= '0;
            r_c2      <= '0;
            r_c3      <= '0;
            r_e       <= '0;
            r_e1      <= '0;
            r_e2      <= '0;
            r_u1      <= '0;
            r_acc     <= '0;
            servo_o   <= '0;
            ch_o      <= '0;
            dataf_oo  <= 1'b0;
            busy_o    <= 1'b0;
            sat_o     <= 1'b0;
            overrun_o <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_hist_e1[i] <= '0;
                r_hist_e2[i] <= '0;
                r_hist_u1[i] <= '0;
            end
        end else begin
            dataf_oo <= 1'b0;
            if (dataf_i && (r_state != S_IDLE)) begin
                overrun_o <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (dataf_i && w_ch_ok) begin
                        r_ch    <= ch_i;
                        r_ref   <= ref_i;
                        r_y     <= y_k_i;
                        r_c1    <= coeff_1;
                        r_c2    <= coeff_2;
                        r_c3    <= coeff_3;
                        busy_o  <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    r_e     <= w_e;
                    r_e1    <= r_hist_e1[r_ch];
                    r_e2    <= r_hist_e2[r_ch];
                    r_u1    <= r_hist_u1[r_ch];
                    r_acc   <= '0;
                    r_state <= S_MAC0;
                end
                S_MAC0: begin
                    r_acc   <= w_acc_nxt;
                    r_state <= S_MAC1;
                end
                S_MAC1: begin
                    r_acc   <= w_acc_nxt;
                    r_state <= S_MAC2;
                end
                S_MAC2: begin
                    r_acc   <= w_acc_nxt;
                    r_state <= S_SAT;
                end
                S_SAT: begin
                    // Result registers load on entry to OUT so they are visible during the OUT cycle.
                    servo_o  <= w_clamped;
                    sat_o    <= w_sat_hi | w_sat_lo;
                    ch_o     <= r_ch;
                    dataf_oo <= 1'b1;
                    r_state  <= S_OUT;
                end
                S_OUT: begin
                    r_hist_u1[r_ch] <= servo_o;
                    r_hist_e2[r_ch] <= r_e1;
                    r_hist_e1[r_ch] <= r_e;
                    busy_o          <= 1'b0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/control_pid_mc.md
# control_pid_mc

Time-multiplexed, parametrised incremental (velocity-form) PID controller for the servo loop. It is the multi-channel successor of the single-channel 8-bit PID. Each accepted sample computes u[k] = sat(u[k-1] + (c1·e[k] + c2·e[k-1] + c3·e[k-2]) >>> FRAC) for the addressed channel, using one shared multiplier over a fixed-latency FSM. It adds per-channel history, fractional coefficients, output saturation with anti-windup, and overrun detection. The block sits between the position sampler (the source of `y_k_i`) and the PWM generator (the consumer of `servo_o`).

## Interface
Parameters:
- DW, 8: width of `ref_i` and `y_k_i` (unsigned).
- CW, 8: coefficient width (signed two's complement).
- OW, 16: `servo_o` width (signed).
- FRAC, 0: fractional bits in the coefficients; the scaled sum is shifted right arithmetically by FRAC.
- NCH, 2: channel count, ≥1; CHW = max(1, clog2(NCH)).

Ports:
- clk_i, in, 1: single clock; everything is synchronous to the rising edge.
- reset, in, 1: synchronous, active-high.
- dataf_i, in, 1: sample strobe; one-cycle pulse.
- ch_i, in, CHW: channel of the sample.
- ref_i, in, DW: setpoint.
- y_k_i, in, DW: measured position.
- coeff_1 / coeff_2 / coeff_3, in, CW each: c1, c2, c3 (signed).
- servo_o, out, OW: saturated control output (signed).
- ch_o, out, CHW: channel of the current `servo_o`.
- dataf_oo, out, 1: one-cycle result-valid pulse.
- busy_o, out, 1: a computation is in progress.
- sat_o, out, 1: the last result was clamped.
- overrun_o, out, 1: sticky flag; a strobe arrived while busy.

## Operation
- **Reset:**
  - `servo_o`, `ch_o`, `dataf_oo`, `busy_o`, `sat_o`, `overrun_o` all go to 0.
  - All per-channel e[k-1], e[k-2], u[k-1] clear to 0.
  - FSM goes to IDLE.
- **Sample capture:** in IDLE, `dataf_i`=1 registers `ch_i`, `ref_i`, `y_k_i`, `coeff_1..3`. Later changes to these inputs do not affect the computation in flight.
- **FSM:** IDLE → ERR → MAC0 → MAC1 → MAC2 → SAT → OUT → IDLE. Every state lasts exactly one cycle.
  - ERR: e = ref − y, signed DW+1 bits (zero-extend both operands first). Load the channel's e1, e2, u1. Clear the accumulator.
  - MAC0 / MAC1 / MAC2: acc += c1·e, then c2·e1, then c3·e2. Each product is signed CW+DW+1 bits. The accumulator is OW+FRAC+4 bits wide, and no intermediate sum may overflow at that width.
  - SAT: t = u1 + (acc >>> FRAC), an arithmetic shift (floor toward −∞). Clamp t to [−2^(OW−1), 2^(OW−1)−1] and set the SAT flag if clamping occurred.
  - OUT: write the clamped value to `servo_o` and to the channel's u[k-1] (anti-windup). Shift history: e2 ← e1, e1 ← e. Drive `ch_o` with the captured channel, `sat_o` with the SAT flag, and pulse `dataf_oo`.
- **Channel isolation:** only the addressed channel's history changes.
- **Invalid channel:** `ch_i` ≥ NCH means the strobe is ignored. No busy, no output, no history change.
- **Strobe while busy:** `dataf_i` in any state other than IDLE is dropped and sets `overrun_o`. The current computation is unaffected. `overrun_o` clears only on reset.
- **Result hold:** `servo_o`, `ch_o`, `sat_o` hold until the next OUT state.

## Timing
- Strobe in cycle T (IDLE) → `busy_o` is high from T+1 through T+6 → `dataf_oo` is high in T+6 only, with `servo_o` valid from T+6 onward.
- A strobe in T+6 (OUT state) is an overrun. The earliest accepted next strobe is T+7, giving a throughput of 1 sample per 7 cycles.
- Reset has priority over everything.
  - Reset asserted mid-computation aborts it: no `dataf_oo`, history cleared, IDLE on the cycle after reset deasserts.
  - Reset and `dataf_i` in the same cycle: the strobe is ignored.

## Test plan
Defaults throughout (DW=8, CW=8, OW=16, FRAC=0, NCH=2).
1. **Reset:** assert reset for 2 cycles → all outputs 0. Then strobe ch0 with c=(1,0,0), ref=0, y=0 → `servo_o`=0 at T+6.
2. **Latency and P-only:** ch0, c=(2,0,0), ref=100, y=90 → `dataf_oo` exactly at T+6, `servo_o`=20, `ch_o`=0, `busy_o` high for T+1..T+6. Repeat the same sample → `servo_o`=40.
3. **History:** ch0 after reset, c=(3, −2 (8'hFE), 1), ref=50. Send y=40, then y=45, then y=50 → `servo_o` = 30, then 25, then 25.
4. **Channel independence:** run scenario 3's first sample on ch0, then send ch1 with c=(1,0,0), ref=20, y=10 → ch1 result is 10, `ch_o`=1. A following ch0 sample continues from 30. Strobe with `ch_i`=2 (invalid) → no response.
5. **Saturation / anti-windup:** c=(127,0,0), ref=255, y=0.
   - First sample → 32385, `sat_o`=0.
   - Second sample → 32767, `sat_o`=1.
   - Then ref=0, y=255 → 382, `sat_o`=0.
6. **Overrun / mid-op reset:**
   - Strobe at T+3 → ignored, `overrun_o`=1, and the result at T+6 is unchanged.
   - New sample, then reset at its T+3 → no `dataf_oo`, outputs 0. A following sample c=(2,0,0), ref=100, y=90 → 20, proving history was cleared.
